line_follow_ctrl: RTL and testbench

//  Line-follower steering controller feeding servo_to_PWM. Samples the IR line-sensor

---
 rtl/line_follow_ctrl.sv | 167 ++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/line_follow_ctrl.sv
// Line-follower steering controller: debounced IR array -> weighted position error -> PD law.
// One control iteration per sample tick; a lost line steers hard toward the last side seen.
module line_follow_ctrl #(
    parameter int unsigned SENSORS      = 8,
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SAMPLE_HZ    = 1000,
    parameter int unsigned KP           = 4,
    parameter int unsigned KD           = 2,
    parameter int unsigned SERVO_CENTER = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SENSORS-1:0] sensors,
    input  logic               enable,
    output logic [7:0]         servo,
    output logic               servo_valid,
    output logic               line_lost
);
    localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned DW  = $clog2(DIV);
    localparam int unsigned IW  = $clog2(SENSORS);
    localparam int unsigned CW  = $clog2(SENSORS + 1);

    localparam logic        [7:0]  Center8 = 8'(SERVO_CENTER);
    localparam logic signed [15:0] KpS     = 16'(KP);
    localparam logic signed [15:0] KdS     = 16'(KD);

    typedef enum logic [1:0] {StIdle, StAccum, StCalc, StOut} state_e;

    logic [SENSORS-1:0] meta_q, sync_q, raw_prev_q, filt_q, stable;
    logic [DW-1:0]      div_q, div_d;
    logic               tick;

    state_e             state_q;
    logic [IW-1:0]      idx_q;
    logic [CW-1:0]      cnt_q;
    logic signed [7:0]  sum_q, e_q, e_prev_q, weight, e_calc;
    logic signed [15:0] corr_q, corr_calc, e_ext, ep_ext;
    logic signed [16:0] target;
    logic [7:0]         clamped;
    logic signed [1:0]  last_dir_q;
    logic               lost_path_q;
    logic [7:0]         servo_q;
    logic               valid_q, lost_q;

    // Sample divider: only runs while enabled, parked at zero otherwise.
    always_comb begin
        tick  = enable && (div_q == DW'(DIV - 1));
        div_d = div_q + 1'b1;
        if (!enable || tick) begin
            div_d = '0;
        end
    end

    // A bit only moves into the filter once two consecutive ticks agree on it.
    assign stable = ~(sync_q ^ raw_prev_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q     <= '0;
            sync_q     <= '0;
            raw_prev_q <= '0;
            filt_q     <= '0;
            div_q      <= '0;
        end else begin
            meta_q <= sensors;
            sync_q <= meta_q;
            div_q  <= div_d;
            if (tick) begin
                raw_prev_q <= sync_q;
                filt_q     <= (filt_q & ~stable) | (sync_q & stable);
            end
        end
    end

    always_comb begin
        weight = 8'(2 * int'(idx_q) - int'(SENSORS) + 1);
        e_calc = sum_q;
        if (cnt_q == CW'(SENSORS)) begin
            e_calc = '0;
        end
        e_ext     = {{8{e_calc[7]}}, e_calc};
        ep_ext    = {{8{e_prev_q[7]}}, e_prev_q};
        corr_calc = KpS * e_ext + KdS * (e_ext - ep_ext);
        target    = {corr_q[15], corr_q} + 17'(SERVO_CENTER);
        clamped   = target[7:0];
        if (target < 0) begin
            clamped = 8'd0;
        end else if (target > 17'sd255) begin
            clamped = 8'd255;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            e_q         <= '0;
            e_prev_q    <= '0;
            corr_q      <= '0;
            last_dir_q  <= '0;
            lost_path_q <= 1'b0;
            servo_q     <= Center8;
            valid_q     <= 1'b0;
            lost_q      <= 1'b0;
        end else if (!enable) begin
            state_q  <= StIdle;
            servo_q  <= Center8;
            e_prev_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q <= StAccum;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                StAccum: begin
                    if (filt_q[idx_q]) begin
                        sum_q <= sum_q + weight;
                        cnt_q <= cnt_q + 1'b1;
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IW'(SENSORS - 1)) begin
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    e_q         <= e_calc;
                    corr_q      <= corr_calc;
                    lost_path_q <= (cnt_q == '0);
                    state_q     <= StOut;
                end
                StOut: begin
                    valid_q <= 1'b1;
                    lost_q  <= lost_path_q;
                    state_q <= StIdle;
                    if (lost_path_q) begin
                        if (last_dir_q < 0) begin
                            servo_q <= 8'd0;
                        end else if (last_dir_q > 0) begin
                            servo_q <= 8'd255;
                        end else begin
                            servo_q <= Center8;
                        end
                    end else begin
                        servo_q    <= clamped;
                        e_prev_q   <= e_q;
                        last_dir_q <= e_q[7] ? 2'sb11 : ((e_q != 0) ? 2'sb01 : 2'sb00);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign servo       = servo_q;
    assign servo_valid = valid_q;
    assign line_lost   = lost_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl: table of per-update sensor patterns and expected
// servo codes for a KP=4 and a KP=20 instance, plus enable-drop and reset corner cases.
module tb_line_follow_ctrl;
    // DIV=12 leaves an idle cycle between iterations so every sample tick is processed.
    localparam int unsigned ClkHz    = 1200;
    localparam int unsigned SampleHz = 100;
    localparam int          Period   = 12;
    localparam int          FirstLat = 22;

    logic       clk;
    logic       rst_n;
    logic [7:0] sensors;
    logic       enable;
    logic [7:0] servo, servo_hi;
    logic       valid, valid_hi;
    logic       lost, lost_hi;

    int n_cmp  = 0;
    int n_fail = 0;

    line_follow_ctrl #(
        .SENSORS(8), .CLK_HZ(ClkHz), .SAMPLE_HZ(SampleHz), .KP(4), .KD(2), .SERVO_CENTER(128)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensors(sensors), .enable(enable),
        .servo(servo), .servo_valid(valid), .line_lost(lost)
    );

    line_follow_ctrl #(
        .SENSORS(8), .CLK_HZ(ClkHz), .SAMPLE_HZ(SampleHz), .KP(20), .KD(2), .SERVO_CENTER(128)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .sensors(sensors), .enable(enable),
        .servo(servo_hi), .servo_valid(valid_hi), .line_lost(lost_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sens;
        int         servo;
        int         servo_hi;
        int         lost;
    } vec_t;

    vec_t tbl[24];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Counts rising edges until servo_valid is seen; returns 999 if it never comes.
    task automatic wait_valid(output int cyc);
        cyc = 999;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic check_out(input string tag, input int s, input int s_hi, input int l);
        check({tag, ".servo"}, int'(servo), s);
        check({tag, ".servo_hi"}, int'(servo_hi), s_hi);
        check({tag, ".lost"}, int'(lost), l);
        check({tag, ".lost_hi"}, int'(lost_hi), l);
        check({tag, ".valid_hi"}, int'(valid_hi), 1);
    endtask

    // Advance to mid-ACCUM of the next iteration, starting right after a valid pulse.
    task automatic to_mid_accum();
        @(posedge clk);
        #1;
        check("pulse_width", int'(valid), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int pulses;

        tbl[0]  = '{8'h18, 128, 128, 0};
        tbl[1]  = '{8'h80, 128, 128, 0};
        tbl[2]  = '{8'h80, 128, 128, 0};
        tbl[3]  = '{8'h80, 170, 255, 0};
        tbl[4]  = '{8'h00, 156, 255, 0};
        tbl[5]  = '{8'h00, 156, 255, 0};
        tbl[6]  = '{8'h00, 255, 255, 1};
        tbl[7]  = '{8'h18, 255, 255, 1};
        tbl[8]  = '{8'h18, 255, 255, 1};
        tbl[9]  = '{8'h18, 114, 114, 0};
        tbl[10] = '{8'h01, 128, 128, 0};
        tbl[11] = '{8'h01, 128, 128, 0};
        tbl[12] = '{8'h01,  86,   0, 0};
        tbl[13] = '{8'h00, 100,   0, 0};
        tbl[14] = '{8'h00, 100,   0, 0};
        tbl[15] = '{8'hFF,   0,   0, 1};
        tbl[16] = '{8'hFF,   0,   0, 1};
        tbl[17] = '{8'h18, 142, 142, 0};
        tbl[18] = '{8'h18, 128, 128, 0};
        tbl[19] = '{8'h18, 128, 128, 0};
        tbl[20] = '{8'hC0, 128, 128, 0};
        tbl[21] = '{8'hC0, 128, 128, 0};
        tbl[22] = '{8'hC0, 200, 255, 0};
        tbl[23] = '{8'hC0, 176, 255, 0};

        rst_n   = 1'b0;
        enable  = 1'b0;
        sensors = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst.servo", int'(servo), 128);
        check("rst.valid", int'(valid), 0);
        check("rst.lost", int'(lost), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_disabled.valid", int'(valid), 0);
        check("idle_disabled.servo", int'(servo), 128);

        // First iteration: line not yet through the debounce, so it reads as lost.
        sensors = 8'h18;
        enable  = 1'b1;
        wait_valid(cyc);
        check("first.latency", cyc, FirstLat);
        check_out("first", 128, 128, 1);

        foreach (tbl[i]) begin
            sensors = tbl[i].sens;
            wait_valid(cyc);
            check($sformatf("vec%0d.period", i), cyc, Period);
            check_out($sformatf("vec%0d", i), tbl[i].servo, tbl[i].servo_hi, tbl[i].lost);
        end

        // enable dropped mid-ACCUM: centred immediately, no pulse while disabled.
        to_mid_accum();
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis.servo", int'(servo), 128);
        check("dis.servo_hi", int'(servo_hi), 128);
        check("dis.valid", int'(valid), 0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (valid || valid_hi) pulses++;
        end
        check("dis.no_pulse", pulses, 0);

        // e_prev was cleared, so the D term sees the full error again.
        enable = 1'b1;
        wait_valid(cyc);
        check("reen.latency", cyc, FirstLat);
        check_out("reen", 200, 255, 0);

        // Reset mid-ACCUM: aborts, filter and last_dir cleared.
        to_mid_accum();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst.servo", int'(servo), 128);
        check("midrst.valid", int'(valid), 0);
        check("midrst.lost", int'(lost), 0);
        wait_valid(cyc);
        check("midrst.latency", cyc, FirstLat);
        check_out("midrst", 128, 128, 1);

        // line_lost holds across an enable drop.
        to_mid_accum();
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis2.lost", int'(lost), 1);
        check("dis2.servo", int'(servo), 128);
        enable = 1'b1;
        wait_valid(cyc);
        check("reen2.latency", cyc, FirstLat);
        check_out("reen2", 200, 255, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
